// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state encoding,
// the NOP word that a flushed IF/ID register holds, and the control-bundle presets.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RUN      = 2'b00,
    S_LU_STALL = 2'b01,
    S_MEM_WAIT = 2'b10,
    S_ERR      = 2'b11
  } state_e;

  // sll $0,$0,0 -- what IF/ID is cleared to when ifid_flush is raised.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic pc_wr;
    logic ifid_wr;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_hold;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = '{pc_wr: 1'b1, ifid_wr: 1'b1, ifid_flush: 1'b0,
                                 idex_bubble: 1'b0, exmem_hold: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{pc_wr: 1'b0, ifid_wr: 1'b0, ifid_flush: 1'b0,
                                    idex_bubble: 1'b0, exmem_hold: 1'b1};
  localparam ctrl_t CTRL_BUBBLE = '{pc_wr: 1'b0, ifid_wr: 1'b0, ifid_flush: 1'b0,
                                    idex_bubble: 1'b1, exmem_hold: 1'b0};
  localparam ctrl_t CTRL_FLUSH = '{pc_wr: 1'b1, ifid_wr: 1'b1, ifid_flush: 1'b1,
                                   idex_bubble: 1'b1, exmem_hold: 1'b0};

  // Register $0 is hard-wired, so a load targeting it never creates a dependency.
  function automatic logic reg_dep(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_load_use.sv
// Combinational load-use hazard detector: a load in EX whose destination is
// read by the instruction currently in ID.
module load_use_detect
  import pipe_stall_ctrl_pkg::*;
(
  input  logic [4:0] ifid_rs_i,
  input  logic [4:0] ifid_rt_i,
  input  logic       ifid_uses_rt_i,
  input  logic [4:0] idex_rt_i,
  input  logic       idex_mem_read_i,
  output logic       lu_o
);

  logic rs_dep;
  logic rt_dep;

  assign rs_dep = reg_dep(idex_rt_i, ifid_rs_i);
  assign rt_dep = ifid_uses_rt_i & reg_dep(idex_rt_i, ifid_rt_i);
  assign lu_o   = idex_mem_read_i & (rs_dep | rt_dep);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: one prioritised FSM
// (miss > taken branch > load-use) with a saturating stall-cycle counter.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int LU_CYCLES = 1,
  parameter int WAIT_MAX  = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic [4:0]       idex_rt,
  input  logic             idex_mem_read,
  input  logic             exmem_br_take,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_wr,
  output logic             ifid_wr,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int              WC_W      = $clog2(WAIT_MAX);
  localparam logic [1:0]      LU_LAST   = 2'(LU_CYCLES - 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_MAX - 1);

  state_e           state_q, state_d;
  logic [1:0]       lu_cnt_q, lu_cnt_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  ctrl_t            ctrl;
  logic             err_c;
  logic             lu;
  logic             miss;

  load_use_detect u_load_use_detect (
    .ifid_rs_i      (ifid_rs),
    .ifid_rt_i      (ifid_rt),
    .ifid_uses_rt_i (ifid_uses_rt),
    .idex_rt_i      (idex_rt),
    .idex_mem_read_i(idex_mem_read),
    .lu_o           (lu)
  );

  assign miss = dmem_req & ~dmem_ready;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    lu_cnt_d   = lu_cnt_q;
    wait_cnt_d = wait_cnt_q;
    ctrl       = CTRL_RUN;
    err_c      = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (miss) begin
          ctrl       = CTRL_FREEZE;
          state_d    = S_MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end else if (exmem_br_take) begin
          ctrl = CTRL_FLUSH;
        end else if (lu) begin
          ctrl = CTRL_BUBBLE;
          if (LU_CYCLES > 1) begin
            state_d  = S_LU_STALL;
            lu_cnt_d = 2'd1;
          end
        end
      end

      S_LU_STALL: begin
        // Remaining bubbles are abandoned on a miss or flush; RUN re-checks lu afterwards.
        if (miss) begin
          ctrl       = CTRL_FREEZE;
          state_d    = S_MEM_WAIT;
          wait_cnt_d = WC_W'(1);
          lu_cnt_d   = 2'd0;
        end else if (exmem_br_take) begin
          ctrl     = CTRL_FLUSH;
          state_d  = S_RUN;
          lu_cnt_d = 2'd0;
        end else begin
          ctrl = CTRL_BUBBLE;
          if (lu_cnt_q == LU_LAST) begin
            state_d  = S_RUN;
            lu_cnt_d = 2'd0;
          end else begin
            lu_cnt_d = lu_cnt_q + 2'd1;
          end
        end
      end

      S_MEM_WAIT: begin
        if (!dmem_ready) begin
          ctrl = CTRL_FREEZE;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = S_ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
          end
        end else begin
          // Hold drops in the completing cycle, so the front end proceeds as in RUN.
          state_d    = S_RUN;
          wait_cnt_d = '0;
          if (exmem_br_take) begin
            ctrl = CTRL_FLUSH;
          end else if (lu) begin
            ctrl = CTRL_BUBBLE;
          end
        end
      end

      S_ERR: begin
        ctrl  = CTRL_FREEZE;
        err_c = 1'b1;
      end
    endcase

    // Reset overrides the decode immediately, independent of the hazard inputs.
    if (rst) begin
      ctrl  = CTRL_RUN;
      err_c = 1'b0;
    end
  end

  // NOTE: only control registers exist here, so all of them are async-reset and
  // sequential state is written with non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      lu_cnt_q    <= '0;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lu_cnt_q   <= lu_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      if (!ctrl.pc_wr && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign pc_wr       = ctrl.pc_wr;
  assign ifid_wr     = ctrl.ifid_wr;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;
  assign exmem_hold  = ctrl.exmem_hold;
  assign err         = err_c;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: two instances (LU_CYCLES=1/WAIT_MAX=16/16-bit count and
// LU_CYCLES=2/WAIT_MAX=4/4-bit count) checked against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;

  // Expected {pc_wr, ifid_wr, ifid_flush, idex_bubble, exmem_hold, err}
  localparam logic [5:0] E_RUN   = 6'b110000;
  localparam logic [5:0] E_LU    = 6'b000100;
  localparam logic [5:0] E_FLUSH = 6'b111100;
  localparam logic [5:0] E_FRZ   = 6'b000010;
  localparam logic [5:0] E_ERR   = 6'b000011;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic       ifid_uses_rt, idex_mem_read, exmem_br_take, dmem_req, dmem_ready;

  logic        a_pc_wr, a_ifid_wr, a_ifid_flush, a_idex_bubble, a_exmem_hold, a_err;
  logic [15:0] a_cnt;
  logic        b_pc_wr, b_ifid_wr, b_ifid_flush, b_idex_bubble, b_exmem_hold, b_err;
  logic [3:0]  b_cnt;

  logic [5:0]  obs_ctl [2];
  logic [15:0] obs_cnt [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: pending bubbles, waiting flag/length, error flag, stall count.
  int m_bub [2];
  int m_len [2];
  int m_stalls [2];
  bit m_wait [2];
  bit m_err [2];

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.LU_CYCLES(1), .WAIT_MAX(16), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_rt(idex_rt), .idex_mem_read(idex_mem_read), .exmem_br_take(exmem_br_take),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_wr(a_pc_wr), .ifid_wr(a_ifid_wr),
    .ifid_flush(a_ifid_flush), .idex_bubble(a_idex_bubble), .exmem_hold(a_exmem_hold),
    .err(a_err), .stall_cnt(a_cnt)
  );

  pipe_stall_ctrl #(.LU_CYCLES(2), .WAIT_MAX(4), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_rt(idex_rt), .idex_mem_read(idex_mem_read), .exmem_br_take(exmem_br_take),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_wr(b_pc_wr), .ifid_wr(b_ifid_wr),
    .ifid_flush(b_ifid_flush), .idex_bubble(b_idex_bubble), .exmem_hold(b_exmem_hold),
    .err(b_err), .stall_cnt(b_cnt)
  );

  always_comb begin
    obs_ctl[0] = {a_pc_wr, a_ifid_wr, a_ifid_flush, a_idex_bubble, a_exmem_hold, a_err};
    obs_ctl[1] = {b_pc_wr, b_ifid_wr, b_ifid_flush, b_idex_bubble, b_exmem_hold, b_err};
    obs_cnt[0] = a_cnt;
    obs_cnt[1] = {12'd0, b_cnt};
  end

  function automatic int lu_n(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int wait_max(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic int cnt_max(input int i);
    return (i == 0) ? 65535 : 15;
  endfunction

  function automatic bit hazard();
    return idex_mem_read && (idex_rt != 0) &&
           ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_bub[i] = 0; m_len[i] = 0; m_stalls[i] = 0; m_wait[i] = 0; m_err[i] = 0;
    end
  endtask

  // Expected outputs for this cycle (count is the value before this cycle),
  // then advances the model as if the clock edge had happened.
  task automatic model_step(input int i, output logic [5:0] e_ctl, output int e_cnt);
    bit miss;
    bit lu;
    miss = dmem_req && !dmem_ready;
    lu   = hazard();
    if (rst) begin
      m_bub[i] = 0; m_len[i] = 0; m_stalls[i] = 0; m_wait[i] = 0; m_err[i] = 0;
      e_ctl = E_RUN;
      e_cnt = 0;
      return;
    end
    e_cnt = m_stalls[i];
    if (m_err[i]) begin
      e_ctl = E_ERR;
    end else if (m_wait[i]) begin
      if (!dmem_ready) begin
        e_ctl = E_FRZ;
        m_len[i]++;
        if (m_len[i] == wait_max(i)) m_err[i] = 1;
      end else begin
        m_wait[i] = 0;
        e_ctl = exmem_br_take ? E_FLUSH : (lu ? E_LU : E_RUN);
      end
    end else if (miss) begin
      e_ctl = E_FRZ; m_wait[i] = 1; m_len[i] = 1; m_bub[i] = 0;
    end else if (exmem_br_take) begin
      e_ctl = E_FLUSH; m_bub[i] = 0;
    end else if (m_bub[i] > 0) begin
      e_ctl = E_LU; m_bub[i]--;
    end else if (lu) begin
      e_ctl = E_LU; m_bub[i] = lu_n(i) - 1;
    end else begin
      e_ctl = E_RUN;
    end
    if (!e_ctl[5] && (m_stalls[i] < cnt_max(i))) m_stalls[i]++;
  endtask

  task automatic set_in(input bit mr, input int irt, input int rs, input int rt,
                        input bit urt, input bit br, input bit req, input bit rdy);
    idex_mem_read = mr;
    idex_rt       = 5'(irt);
    ifid_rs       = 5'(rs);
    ifid_rt       = 5'(rt);
    ifid_uses_rt  = urt;
    exmem_br_take = br;
    dmem_req      = req;
    dmem_ready    = rdy;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] e;
    int c;
    rst = 1'b1;
    model_clear();
    for (int k = 0; k < 3; k++) begin
      set_in(1, 5, 5, 5, 1, k == 1, k == 2, 0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        model_step(i, e, c);
        n_tests++;
        if (obs_ctl[i] !== e) begin
          n_fail++; $display("FAIL reset_ctl dut%0d got %b want %b", i, obs_ctl[i], e);
        end
        n_tests++;
        if (obs_cnt[i] !== 16'(c)) begin
          n_fail++; $display("FAIL reset_cnt dut%0d got %0d want %0d", i, obs_cnt[i], c);
        end
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_load_use_rs();
    logic [5:0] e;
    int c;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k == 0) set_in(1, 5, 5, 0, 0, 0, 0, 0);
      else        set_in(0, 0, 1, 2, 0, 0, 0, 0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        model_step(i, e, c);
        n_tests++;
        if (obs_ctl[i] !== e) begin
          n_fail++; $display("FAIL lu_rs_ctl dut%0d cyc%0d got %b want %b", i, k, obs_ctl[i], e);
        end
        n_tests++;
        if (obs_cnt[i] !== 16'(c)) begin
          n_fail++; $display("FAIL lu_rs_cnt dut%0d cyc%0d got %0d want %0d", i, k, obs_cnt[i], c);
        end
      end
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (a_cnt !== 16'd1) begin
      n_fail++; $display("FAIL lu_rs_total got %0d want 1", a_cnt);
    end
  endtask

  task automatic test_non_hazard();
    logic [5:0] e;
    int c;
    int tbl [5][5] = '{'{1, 7, 3, 7, 0}, '{1, 0, 0, 0, 1}, '{0, 6, 6, 6, 1},
                       '{1, 4, 2, 2, 1}, '{1, 9, 2, 9, 1}};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) set_in(tbl[k/2][0] != 0, tbl[k/2][1], tbl[k/2][2], tbl[k/2][3],
                             tbl[k/2][4] != 0, 0, 0, 0);
      else            set_in(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        model_step(i, e, c);
        n_tests++;
        if (obs_ctl[i] !== e) begin
          n_fail++; $display("FAIL nonhaz_ctl dut%0d cyc%0d got %b want %b", i, k, obs_ctl[i], e);
        end
        n_tests++;
        if (obs_cnt[i] !== 16'(c)) begin
          n_fail++; $display("FAIL nonhaz_cnt dut%0d cyc%0d got %0d want %0d", i, k, obs_cnt[i], c);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Hazard held two cycles, then a hazard whose second bubble meets a taken branch.
  task automatic test_multi_bubble();
    logic [5:0] e;
    int c;
    bit hz [8] = '{1, 1, 0, 0, 1, 0, 0, 0};
    bit br [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_in(hz[k], 3, 3, 0, 0, br[k], 0, 0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        model_step(i, e, c);
        n_tests++;
        if (obs_ctl[i] !== e) begin
          n_fail++; $display("FAIL multi_bub_ctl dut%0d cyc%0d got %b want %b", i, k, obs_ctl[i], e);
        end
        n_tests++;
        if (obs_cnt[i] !== 16'(c)) begin
          n_fail++; $display("FAIL multi_bub_cnt dut%0d cyc%0d got %0d want %0d", i, k, obs_cnt[i], c);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_branch_vs_lu();
    logic [5:0] e;
    int c;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      if (k == 0) set_in(1, 8, 1, 8, 1, 1, 0, 0);
      else        set_in(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        model_step(i, e, c);
        n_tests++;
        if (obs_ctl[i] !== e) begin
          n_fail++; $display("FAIL br_lu_ctl dut%0d cyc%0d got %b want %b", i, k, obs_ctl[i], e);
        end
        n_tests++;
        if (obs_cnt[i] !== 16'(c)) begin
          n_fail++; $display("FAIL br_lu_cnt dut%0d cyc%0d got %0d want %0d", i, k, obs_cnt[i], c);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mem_wait();
    logic [5:0] e;
    int c;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_in(0, 0, 0, 0, 0, 0, k < 4, k == 3);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        model_step(i, e, c);
        n_tests++;
        if (obs_ctl[i] !== e) begin
          n_fail++; $display("FAIL mem_wait_ctl dut%0d cyc%0d got %b want %b", i, k, obs_ctl[i], e);
        end
        n_tests++;
        if (obs_cnt[i] !== 16'(c)) begin
          n_fail++; $display("FAIL mem_wait_cnt dut%0d cyc%0d got %0d want %0d", i, k, obs_cnt[i], c);
        end
      end
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (a_cnt !== 16'd3) begin
      n_fail++; $display("FAIL mem_wait_total got %0d want 3", a_cnt);
    end
  endtask

  task automatic test_timeout_and_reset();
    logic [5:0] e;
    int c;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      set_in(k == 5, 2, 2, 0, 0, k == 6, 1, 0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        model_step(i, e, c);
        n_tests++;
        if (obs_ctl[i] !== e) begin
          n_fail++; $display("FAIL timeout_ctl dut%0d cyc%0d got %b want %b", i, k, obs_ctl[i], e);
        end
        n_tests++;
        if (obs_cnt[i] !== 16'(c)) begin
          n_fail++; $display("FAIL timeout_cnt dut%0d cyc%0d got %0d want %0d", i, k, obs_cnt[i], c);
        end
      end
      @(posedge clk);
      #1;
    end
    #2;
    n_tests++;
    if (b_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_err_sticky got %b want 1", b_err);
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (obs_ctl[i] !== E_RUN) begin
        n_fail++; $display("FAIL async_rst_ctl dut%0d got %b want %b", i, obs_ctl[i], E_RUN);
      end
      n_tests++;
      if (obs_cnt[i] !== 16'd0) begin
        n_fail++; $display("FAIL async_rst_cnt dut%0d got %0d want 0", i, obs_cnt[i]);
      end
    end
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [5:0] e;
    int c;
    int rdy_pct;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rdy_pct = (k < 1500) ? 60 : 20;
      set_in($urandom_range(0, 1) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), $urandom_range(0, 1) != 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 99) < 30,
             $urandom_range(0, 99) < rdy_pct);
      rst = ($urandom_range(0, 149) == 0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        model_step(i, e, c);
        n_tests++;
        if (obs_ctl[i] !== e) begin
          n_fail++; $display("FAIL rand_ctl dut%0d cyc%0d got %b want %b", i, k, obs_ctl[i], e);
        end
        n_tests++;
        if (obs_cnt[i] !== 16'(c)) begin
          n_fail++; $display("FAIL rand_cnt dut%0d cyc%0d got %0d want %0d", i, k, obs_cnt[i], c);
        end
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_load_use_rs();
    test_non_hazard();
    test_multi_bubble();
    test_branch_vs_lu();
    test_mem_wait();
    test_timeout_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
